// File: rtl/wordline_sequencer_if.sv
// rtl/wordline_sequencer_if.sv - request channel between array controller and word-line sequencer
interface wordline_sequencer_if #(
    parameter int N_BITS = 8
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        mode_i;
    logic [N_BITS-1:0] addr_ni;
    logic [N_BITS-1:0] count_i;

    // The controller issues requests and watches ready.
    modport master (
        output req_valid_i,
        output mode_i,
        output addr_ni,
        output count_i,
        input  req_ready_o
    );

    // The sequencer consumes requests and drives ready.
    modport slave (
        input  req_valid_i,
        input  mode_i,
        input  addr_ni,
        input  count_i,
        output req_ready_o
    );
endinterface

// File: rtl/wordline_sequencer.sv
// rtl/wordline_sequencer.sv - registered one-hot word-line pulse sequencer (single/scan/broadcast)
module wordline_sequencer #(
    parameter int N_BITS       = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ena_i,
    wordline_sequencer_if.slave      req,
    output logic [(2**N_BITS)-1:0]   wl_o,
    output logic [(2**N_BITS)-1:0]   wl_no,
    output logic [N_BITS-1:0]        row_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int ROWS = 2**N_BITS;
    localparam int PW   = $clog2(PULSE_CYCLES + 1);
    // Keep the gap counter at least one bit wide even when gaps are disabled.
    localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] MODE_SCAN  = 2'b01;
    localparam logic [1:0] MODE_BCAST = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [ROWS-1:0]     wl_q, wl_d;
    logic [N_BITS-1:0]   row_q, row_d;
    logic [N_BITS-1:0]   rem_q, rem_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic                bcast_q, bcast_d;
    logic                done_q, done_d;
    logic                ready;
    logic [N_BITS-1:0]   row_inc;
    logic [N_BITS-1:0]   start_row;

    function automatic logic [ROWS-1:0] onehot(input logic [N_BITS-1:0] r);
        logic [ROWS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Ready is forced low while reset is held so nothing upstream sees a spurious accept.
    assign ready           = ena_i && rst_ni && (state_q == IDLE);
    assign req.req_ready_o = ready;

    assign start_row = ~req.addr_ni;
    assign row_inc   = row_q + N_BITS'(1);

    assign wl_o   = wl_q;
    assign wl_no  = ~wl_q;
    assign row_o  = row_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

    // State and datapath registers; word lines are computed one cycle ahead so they leave a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wl_q    <= '0;
            row_q   <= '0;
            rem_q   <= '0;
            pcnt_q  <= '0;
            gcnt_q  <= '0;
            bcast_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wl_q    <= wl_d;
            row_q   <= row_d;
            rem_q   <= rem_d;
            pcnt_q  <= pcnt_d;
            gcnt_q  <= gcnt_d;
            bcast_q <= bcast_d;
            done_q  <= done_d;
        end
    end

    // Next-state, next word-line pattern and counter updates.
    always_comb begin
        state_d = state_q;
        wl_d    = wl_q;
        row_d   = row_q;
        rem_d   = rem_q;
        pcnt_d  = pcnt_q;
        gcnt_d  = gcnt_q;
        bcast_d = bcast_q;
        done_d  = 1'b0;

        if (!ena_i) begin
            // Abort: drop the word lines, clear counters, keep the last row visible.
            state_d = IDLE;
            wl_d    = '0;
            rem_d   = '0;
            pcnt_d  = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req.req_valid_i && ready) begin
                        // Only broadcast needs remembering; scan-ness lives in the row count.
                        bcast_d = (req.mode_i == MODE_BCAST);
                        row_d   = start_row;
                        rem_d   = (req.mode_i == MODE_SCAN) ? req.count_i : '0;
                        pcnt_d  = PW'(PULSE_CYCLES);
                        wl_d    = (req.mode_i == MODE_BCAST) ? '1 : onehot(start_row);
                        state_d = PULSE;
                    end
                end

                PULSE: begin
                    if (pcnt_q == PW'(1)) begin
                        if (rem_q == '0) begin
                            state_d = IDLE;
                            wl_d    = '0;
                            pcnt_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            rem_d = rem_q - N_BITS'(1);
                            if (GAP_CYCLES == 0) begin
                                // Back-to-back: the register swaps rows in one edge, never two lines high.
                                row_d  = row_inc;
                                wl_d   = onehot(row_inc);
                                pcnt_d = PW'(PULSE_CYCLES);
                            end else begin
                                state_d = GAP;
                                wl_d    = '0;
                                pcnt_d  = '0;
                                gcnt_d  = GW'(GAP_CYCLES);
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q - PW'(1);
                    end
                end

                GAP: begin
                    if (gcnt_q == GW'(1)) begin
                        state_d = PULSE;
                        row_d   = row_inc;
                        wl_d    = onehot(row_inc);
                        pcnt_d  = PW'(PULSE_CYCLES);
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q - GW'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    wl_d    = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wordline_sequencer.sv
// tb/tb_wordline_sequencer.sv - table-driven scoreboard bench for wordline_sequencer
module tb_wordline_sequencer;

    localparam int NB   = 8;
    localparam int ROWS = 2**NB;
    localparam int P    = 2;
    localparam int G1   = 1;
    localparam int G2   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena1 = 1'b0;
    logic ena2 = 1'b0;

    always #5 clk = ~clk;

    wordline_sequencer_if #(.N_BITS(NB)) if1 ();
    wordline_sequencer_if #(.N_BITS(NB)) if2 ();

    logic [ROWS-1:0] wl1, wl1_n, wl2, wl2_n;
    logic [NB-1:0]   row1, row2;
    logic            busy1, done1, busy2, done2;

    wordline_sequencer #(.N_BITS(NB), .PULSE_CYCLES(P), .GAP_CYCLES(G1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ena_i  (ena1),
        .req    (if1),
        .wl_o   (wl1),
        .wl_no  (wl1_n),
        .row_o  (row1),
        .busy_o (busy1),
        .done_o (done1)
    );

    wordline_sequencer #(.N_BITS(NB), .PULSE_CYCLES(P), .GAP_CYCLES(G2)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ena_i  (ena2),
        .req    (if2),
        .wl_o   (wl2),
        .wl_no  (wl2_n),
        .row_o  (row2),
        .busy_o (busy2),
        .done_o (done2)
    );

    typedef struct {
        logic [ROWS-1:0] wl;
        logic [NB-1:0]   row;
        logic            busy;
        logic            done;
        logic            ready;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [NB-1:0] addr_n;
        logic [NB-1:0] count;
        logic [NB-1:0] exp_last;
        int          exp_done;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [ROWS-1:0] act, input logic [ROWS-1:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req_v);
        end
    endtask

    // Model of one request: per-cycle outputs from T+1 through the done cycle.
    task automatic push_req(input logic [1:0] mode, input logic [NB-1:0] start, input int cnt, input int gap);
        exp_t e;
        int n;
        logic [NB-1:0] r;
        logic bc;
        bc = (mode == 2'b10);
        n  = (mode == 2'b01) ? cnt + 1 : 1;
        r  = start;
        for (int k = 0; k < n; k++) begin
            r = start + NB'(k);
            for (int p = 0; p < P; p++) begin
                e.wl = bc ? {ROWS{1'b1}} : ({{(ROWS-1){1'b0}}, 1'b1} << r);
                e.row = r; e.busy = 1'b1; e.done = 1'b0; e.ready = 1'b0;
                sb.push_back(e);
            end
            if (k < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    e.wl = '0; e.row = r; e.busy = 1'b1; e.done = 1'b0; e.ready = 1'b0;
                    sb.push_back(e);
                end
            end
        end
        e.wl = '0; e.row = r; e.busy = 1'b0; e.done = 1'b1; e.ready = 1'b1;
        sb.push_back(e);
    endtask

    task automatic push_idle(input logic [NB-1:0] r);
        exp_t e;
        e.wl = '0; e.row = r; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
        sb.push_back(e);
    endtask

    task automatic check_cycle(input string name, input int idx, input logic [ROWS-1:0] wl,
                               input logic [ROWS-1:0] wln, input logic [NB-1:0] row,
                               input logic busy, input logic done, input logic ready);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s[%0d]: scoreboard empty", name, idx);
        end else begin
            e = sb.pop_front();
            if (wl !== e.wl || wln !== ~e.wl || row !== e.row || busy !== e.busy ||
                done !== e.done || ready !== e.ready) begin
                n_fail++;
                $display("FAIL %s[%0d]: got wl=%0h wl_n_ok=%b row=%0d busy=%b done=%b ready=%b; want wl=%0h row=%0d busy=%b done=%b ready=%b",
                         name, idx, wl, (wln === ~wl), row, busy, done, ready,
                         e.wl, e.row, e.busy, e.done, e.ready);
            end
        end
    endtask

    // Present a request on DUT1 and return once the accepting edge has passed.
    task automatic issue1(input logic [1:0] mode, input logic [NB-1:0] addr_n, input logic [NB-1:0] count,
                          output logic ok);
        int w;
        @(negedge clk);
        if1.mode_i = mode; if1.addr_ni = addr_n; if1.count_i = count; if1.req_valid_i = 1'b1;
        w = 0;
        while (!if1.req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = if1.req_ready_o;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: ready stayed %b, want 1", if1.req_ready_o);
            if1.req_valid_i = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic ok;
        int idx, done_at;
        sb.delete();
        push_req(v.mode, ~v.addr_n, int'(v.count), G1);
        push_idle(v.exp_last);
        issue1(v.mode, v.addr_n, v.count, ok);
        if (ok) begin
            idx = 0; done_at = -1;
            while (sb.size() > 0) begin
                @(negedge clk);
                if (idx == 0) if1.req_valid_i = 1'b0;
                idx++;
                if (done1 === 1'b1 && done_at < 0) done_at = idx;
                check_cycle(v.name, idx, wl1, wl1_n, row1, busy1, done1, if1.req_ready_o);
            end
            chk({v.name, "_done_latency"}, ROWS'(done_at), ROWS'(v.exp_done));
            chk({v.name, "_final_row"}, ROWS'(row1), ROWS'(v.exp_last));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, want completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        logic done_seen;
        int idx;

        vecs[0] = '{"single",     2'b00, 8'hFC, 8'h05, 8'd3,   3};
        vecs[1] = '{"scan_wrap4", 2'b01, 8'h01, 8'h03, 8'd1,   12};
        vecs[2] = '{"bcast",      2'b10, 8'hF0, 8'h07, 8'd15,  3};
        vecs[3] = '{"mode11",     2'b11, 8'h00, 8'h09, 8'd255, 3};
        vecs[4] = '{"scan_one",   2'b01, 8'hFF, 8'h00, 8'd0,   3};
        vecs[5] = '{"scan_two",   2'b01, 8'h00, 8'h01, 8'd0,   6};
        vecs[6] = '{"scan_full",  2'b01, 8'h7F, 8'hFF, 8'd127, 768};

        if1.req_valid_i = 1'b0; if1.mode_i = 2'b00; if1.addr_ni = '1; if1.count_i = '0;
        if2.req_valid_i = 1'b0; if2.mode_i = 2'b00; if2.addr_ni = '1; if2.count_i = '0;

        // Reset state with enable already high: ready must still be low.
        ena1 = 1'b1; ena2 = 1'b1;
        #12;
        chk("rst_wl", wl1, '0);
        chk("rst_wl_n", wl1_n, {ROWS{1'b1}});
        chk("rst_ready", ROWS'(if1.req_ready_o), '0);
        chk("rst_busy_done", ROWS'({busy1, done1}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", ROWS'(if1.req_ready_o), ROWS'(1));

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a scan, sampled before any clock edge.
        issue1(2'b01, 8'h01, 8'h03, ok);
        @(negedge clk); if1.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wl", wl1, '0);
        chk("midrst_wl_n", wl1_n, {ROWS{1'b1}});
        chk("midrst_row", ROWS'(row1), '0);
        chk("midrst_busy", ROWS'(busy1), '0);
        chk("midrst_done", ROWS'(done1), '0);
        chk("midrst_ready", ROWS'(if1.req_ready_o), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort: drop enable during the second pulse of a scan starting at row 0.
        issue1(2'b01, 8'hFF, 8'h03, ok);
        @(negedge clk); if1.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_second_pulse", wl1, ROWS'(2));
        ena1 = 1'b0;
        @(negedge clk);
        chk("abort_wl", wl1, '0);
        chk("abort_busy", ROWS'(busy1), '0);
        chk("abort_row_hold", ROWS'(row1), ROWS'(1));
        chk("abort_ready_low", ROWS'(if1.req_ready_o), '0);
        done_seen = done1;
        repeat (5) begin
            @(negedge clk);
            done_seen = done_seen | done1;
        end
        chk("abort_no_done", ROWS'(done_seen), '0);
        ena1 = 1'b1;
        #1;
        chk("abort_ready_back", ROWS'(if1.req_ready_o), ROWS'(1));
        run_vec('{"after_abort", 2'b00, 8'hFE, 8'h00, 8'd1, 3});

        // Handshake on the gapless instance: valid held high throughout, second request
        // taken in the done cycle of the first.
        sb.delete();
        push_req(2'b01, 8'd2, 2, G2);
        push_req(2'b00, 8'd15, 0, G2);
        push_idle(8'd15);
        @(negedge clk);
        if2.mode_i = 2'b01; if2.addr_ni = ~8'd2; if2.count_i = 8'd2; if2.req_valid_i = 1'b1;
        idx = 0;
        while (!if2.req_ready_o && idx < 20) begin
            @(negedge clk);
            idx++;
        end
        chk("hs_first_ready", ROWS'(if2.req_ready_o), ROWS'(1));
        @(posedge clk);
        idx = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            if (idx == 0) begin
                if2.mode_i = 2'b00; if2.addr_ni = ~8'd15; if2.count_i = 8'd0;
            end
            if (idx == 7) if2.req_valid_i = 1'b0;
            idx++;
            check_cycle("handshake", idx, wl2, wl2_n, row2, busy2, done2, if2.req_ready_o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wordline_sequencer.md
# wordline_sequencer

Registered, parametrised successor to the combinational row decoder. It accepts a row request over a valid/ready handshake and drives the one-hot word-line bus with timed pulses. Three modes are supported: single row, auto-incrementing scan over a row range with wrap-around, and broadcast to all rows. It sits between the array controller and the word-line drivers. It provides both true and complementary word-line outputs, and takes an active-low address input as the previous decoder did.

## Interface
- N_BITS, 8: row address width; the array has 2**N_BITS rows.
- PULSE_CYCLES, 2: cycles each word-line pulse stays high; legal range ≥1.
- GAP_CYCLES, 1: all-low cycles between consecutive scan pulses; legal range ≥0.

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- ena_i  in  1  global enable; low aborts any operation.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; equals ena_i && state==IDLE, and is 0 while rst_ni is low.
- mode_i  in  2  operation select: 00 SINGLE, 01 SCAN, 10 BROADCAST, 11 treated as SINGLE.
- addr_ni  in  N_BITS  start row, active-low; row = ~addr_ni.
- count_i  in  N_BITS  SCAN only; the scan visits count_i+1 rows.
- wl_o  out  2**N_BITS  word lines, registered.
- wl_no  out  2**N_BITS  bitwise complement of wl_o.
- row_o  out  N_BITS  current row, true polarity, registered.
- busy_o  out  1  high in any non-IDLE state.
- done_o  out  1  one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, PULSE, GAP.
- Acceptance occurs when req_valid_i && req_ready_o at a rising edge. On acceptance the block:
  - latches mode, start row ~addr_ni and count_i;
  - loads the pulse counter with PULSE_CYCLES and the remaining-row count;
  - moves to PULSE.
- PULSE behaviour by mode:
  - SINGLE and SCAN: wl_o is one-hot at row_o.
  - BROADCAST: wl_o is all ones and row_o holds the start row.
- PULSE exit: after PULSE_CYCLES cycles, the FSM goes to GAP if rows remain, or to IDLE if none remain.
  - If GAP_CYCLES=0 it skips GAP and goes straight to PULSE with the next row, so pulses run back-to-back.
- GAP: wl_o is all zero and row_o is unchanged. After GAP_CYCLES cycles, the FSM goes to PULSE and row_o increments.
- Row increment is modulo 2**N_BITS, so 2**N_BITS-1 wraps to 0. With count_i = 2**N_BITS-1 every row is visited exactly once.
- The final pulse is never followed by GAP. The transition into IDLE asserts done_o for exactly one cycle.
- Requests while busy are not accepted because ready is low, and have no effect.
- ena_i low in any state: at the next edge the FSM goes to IDLE, wl_o clears to 0 and counters clear. done_o is not asserted, and row_o holds its value.
- Reset values: wl_o=0, wl_no=all ones, row_o=0, busy_o=0, done_o=0, state IDLE.
- wl_no is always exactly ~wl_o, with no skew cycle.

## Timing
- Acceptance edge is T. The first pulse is visible from T+1 and spans T+1..T+PULSE_CYCLES.
- Word lines active for row k (0-based within the request) from T+1+k*(PULSE_CYCLES+GAP_CYCLES).
- SCAN occupancy: (count_i+1)*PULSE_CYCLES + count_i*GAP_CYCLES cycles. done_o is asserted in the following cycle.
- SINGLE and BROADCAST: done_o at T+PULSE_CYCLES+1.
- During the done_o cycle the FSM is IDLE and req_ready_o is high. A new request accepted there produces its first pulse on the next cycle, giving one idle cycle between requests.
- At most one word line is high in SINGLE and SCAN in any cycle, including across row transitions.

## Test plan
- Reset: assert rst_ni low mid-scan, with no clock edge required.
  -> wl_o=0, wl_no=all ones, row_o=0, busy_o=0, done_o=0, req_ready_o=0.
- SINGLE, N_BITS=8, P=2, G=1, addr_ni=8'hFC.
  -> wl_o[3] high at T+1 and T+2 only; done_o at T+3; req_ready_o high at T+3.
- SCAN, addr_ni=8'h01 (row 254), count_i=3.
  -> rows 254, 255, 0, 1, each 2 cycles with 1 idle cycle between; activity spans T+1..T+11; done_o at T+12; row_o=1 at the end.
- BROADCAST with P=2.
  -> all 256 wl_o high at T+1..T+2, wl_no all zero; done_o at T+3; then wl_o=0.
- Abort: drop ena_i during the second pulse of a SCAN.
  -> wl_o=0 at the next edge, done_o never asserted, busy_o=0. After ena_i returns high, req_ready_o=1 and a SINGLE request completes normally.
- Handshake: hold req_valid_i high throughout a SCAN with G=0.
  -> no acceptance while busy; pulses back-to-back with no gap; a second request is accepted in the done_o cycle and its first pulse appears one cycle later.
